// File: rtl/ebus_arb_pkg.sv
// Shared defaults, lane slice type and the odd-parity helper for the EBUS lane arbiter.
package ebus_arb_pkg;

    localparam int LANE_W_DEF = 6;
    localparam int WIDTH_DEF  = 36;
    // Parity helper input width; narrower buses are zero-extended, which leaves parity unchanged.
    localparam int PAR_MAX_W  = 64;

    typedef logic [LANE_W_DEF-1:0] lane_t;

    function automatic logic odd_parity(input logic [PAR_MAX_W-1:0] d);
        return ~^d;
    endfunction

endpackage

// File: rtl/ebus_lane_pick.sv
// Per-lane priority pick: lowest-index candidate wins; also reports the runner-up for conflict capture.
module ebus_lane_pick
#(
    parameter  int N_DRV = 24,
    localparam int DW    = $clog2(N_DRV)
) (
    input  logic [N_DRV-1:0] i_cand,
    output logic [DW-1:0]    o_win,
    output logic [DW-1:0]    o_sec,
    output logic             o_any,
    output logic             o_multi
);

    // Scanning downward lets each lower hit push the previous winner into the runner-up slot.
    always_comb begin
        o_win = '0;
        o_sec = '0;
        for (int i = N_DRV - 1; i >= 0; i--) begin
            if (i_cand[i]) begin
                o_sec = o_win;
                o_win = DW'(i);
            end
        end
    end

    assign o_any   = |i_cand;
    assign o_multi = |(i_cand & (i_cand - N_DRV'(1)));

endmodule

// File: rtl/ebus_lane_arb.sv
// EBUS lane arbiter: per-lane priority merge, registered odd parity, sticky conflict/stuck diagnostics.
// Define EBUS_CONFLICT_LOG_EN to build the conflict logging outputs; otherwise they are tied to 0.
module ebus_lane_arb
    import ebus_arb_pkg::*;
#(
    parameter  int N_DRV     = 24,
    parameter  int WIDTH     = WIDTH_DEF,
    parameter  int LANE_W    = LANE_W_DEF,
    parameter  int STUCK_MAX = 1024,
    localparam int LANES     = WIDTH / LANE_W,
    localparam int DW        = $clog2(N_DRV),
    localparam int LW        = $clog2(LANES)
) (
    input  logic                   clk,
    input  logic                   reset_l,
    input  logic [N_DRV-1:0]       drv_driving,
    input  logic [N_DRV*WIDTH-1:0] drv_data,
    input  logic [N_DRV*LANES-1:0] drv_lanes,
    input  logic                   diag_clr,
    output logic [WIDTH-1:0]       ebus_data,
    output logic                   ebus_parity,
    output logic                   ebus_parity_active,
    output logic [LANES*DW-1:0]    lane_owner,
    output logic                   conflict,
    output logic [LW-1:0]          conflict_lane,
    output logic [2*DW-1:0]        conflict_drv,
    output logic [7:0]             conflict_cnt,
    output logic                   stuck,
    output logic [DW-1:0]          stuck_drv
);

    localparam logic [15:0] RUN_MAX = 16'(STUCK_MAX);

    logic [LANES-1:0][N_DRV-1:0] w_cand;
    logic [LANES-1:0][DW-1:0]    w_win;
    logic [LANES-1:0][DW-1:0]    w_sec;
    logic [LANES-1:0]            w_any;
    logic [LANES-1:0]            w_multi;
    logic [WIDTH-1:0]            w_data;

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        w_cand = '0;
        for (int k = 0; k < LANES; k++) begin
            for (int i = 0; i < N_DRV; i++) begin
                w_cand[k][i] = drv_driving[i] & drv_lanes[i*LANES + k];
            end
        end
    end

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        ebus_lane_pick #(.N_DRV(N_DRV)) u_pick (
            .i_cand  (w_cand[k]),
            .o_win   (w_win[k]),
            .o_sec   (w_sec[k]),
            .o_any   (w_any[k]),
            .o_multi (w_multi[k])
        );
    end

    always_comb begin
        w_data = '0;
        for (int k = 0; k < LANES; k++) begin
            if (w_any[k]) begin
                w_data[k*LANE_W +: LANE_W] = drv_data[int'(w_win[k])*WIDTH + k*LANE_W +: LANE_W];
            end
        end
    end

    logic [WIDTH-1:0]    r_data;
    logic                r_parity;
    logic                r_par_act;
    logic [LANES*DW-1:0] r_owner;

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
            r_data    <= '0;
            r_parity  <= 1'b1;
            r_par_act <= 1'b0;
            r_owner   <= '0;
        end else begin
            r_data    <= w_data;
            r_parity  <= odd_parity(PAR_MAX_W'(w_data));
            r_par_act <= |w_any;
            r_owner   <= w_win;
        end
    end

    assign ebus_data          = r_data;
    assign ebus_parity        = r_parity;
    assign ebus_parity_active = r_par_act;
    assign lane_owner         = r_owner;

`ifdef EBUS_CONFLICT_LOG_EN
    logic            w_conf_any;
    logic [LW-1:0]   w_conf_lane;
    logic [2*DW-1:0] w_conf_pair;
    logic            r_conflict;
    logic [LW-1:0]   r_conflict_lane;
    logic [2*DW-1:0] r_conflict_drv;
    logic [7:0]      r_conflict_cnt;

    always_comb begin
        w_conf_any  = |w_multi;
        w_conf_lane = '0;
        w_conf_pair = '0;
        for (int k = LANES - 1; k >= 0; k--) begin
            if (w_multi[k]) begin
                w_conf_lane = LW'(k);
                w_conf_pair = {w_win[k], w_sec[k]};
            end
        end
    end

    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
            r_conflict      <= 1'b0;
            r_conflict_lane <= '0;
            r_conflict_drv  <= '0;
            r_conflict_cnt  <= '0;
        end else if (diag_clr) begin
            r_conflict      <= 1'b0;
            r_conflict_lane <= '0;
            r_conflict_drv  <= '0;
            r_conflict_cnt  <= '0;
        end else if (w_conf_any) begin
            if (!r_conflict) begin
                r_conflict      <= 1'b1;
                r_conflict_lane <= w_conf_lane;
                r_conflict_drv  <= w_conf_pair;
            end
            if (r_conflict_cnt != 8'hFF) begin
                r_conflict_cnt <= r_conflict_cnt + 8'd1;
            end
        end
    end

    assign conflict      = r_conflict;
    assign conflict_lane = r_conflict_lane;
    assign conflict_drv  = r_conflict_drv;
    assign conflict_cnt  = r_conflict_cnt;
`else
    logic w_unused_conf;
    assign w_unused_conf = ^{w_multi, w_sec};

    assign conflict      = 1'b0;
    assign conflict_lane = '0;
    assign conflict_drv  = '0;
    assign conflict_cnt  = '0;
`endif

    logic [15:0]   r_run [N_DRV];
    logic          r_stuck;
    logic [DW-1:0] r_stuck_drv;
    logic          w_stuck_hit;
    logic [DW-1:0] w_stuck_idx;

    // A driver "reaches" STUCK_MAX on the edge its run counter steps from STUCK_MAX-1.
    always_comb begin
        w_stuck_hit = 1'b0;
        w_stuck_idx = '0;
        for (int i = N_DRV - 1; i >= 0; i--) begin
            if (drv_driving[i] && (r_run[i] == RUN_MAX - 16'd1)) begin
                w_stuck_hit = 1'b1;
                w_stuck_idx = DW'(i);
            end
        end
    end

    // NOTE: the run counters are control state, not storage, so each one is reset explicitly.
    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
            for (int i = 0; i < N_DRV; i++) r_run[i] <= '0;
            r_stuck     <= 1'b0;
            r_stuck_drv <= '0;
        end else if (diag_clr) begin
            for (int i = 0; i < N_DRV; i++) r_run[i] <= '0;
            r_stuck     <= 1'b0;
            r_stuck_drv <= '0;
        end else begin
            for (int i = 0; i < N_DRV; i++) begin
                if (!drv_driving[i]) begin
                    r_run[i] <= '0;
                end else if (r_run[i] != RUN_MAX) begin
                    r_run[i] <= r_run[i] + 16'd1;
                end
            end
            if (!r_stuck && w_stuck_hit) begin
                r_stuck     <= 1'b1;
                r_stuck_drv <= w_stuck_idx;
            end
        end
    end

    assign stuck     = r_stuck;
    assign stuck_drv = r_stuck_drv;

endmodule

// File: doc/ebus_lane_arb.md
# ebus_lane_arb

Parametrised EBUS data arbiter for the KL10 backplane, replacing the hand-written priority if/else chain that merges module EBUS drivers. Each driver presents a driving flag, 36-bit data, and a per-lane ownership mask, so slice drivers (CRM, EDP) merge naturally instead of through special-cased groups. The output is registered, with odd parity. Sticky diagnostics flag lane conflicts and drivers that never release the bus, for the front-end simulator to read.

## Interface
- N_DRV, 24: number of EBUS drivers; index 0 has highest priority.
- WIDTH, 36: EBUS data width.
- LANE_W, 6: lane width; WIDTH must be a multiple of LANE_W. LANES = WIDTH/LANE_W.
- STUCK_MAX, 1024: consecutive driving cycles after which a driver is flagged stuck; minimum 2.
- clk  in  1  EBUS-domain clock.
- reset_l  in  1  asynchronous, active-low reset.
- drv_driving  in  N_DRV  per-driver driving flag.
- drv_data  in  N_DRV*WIDTH  driver i occupies bits [i*WIDTH +: WIDTH]; bit 0 of each slice is EBUS D00.
- drv_lanes  in  N_DRV*LANES  lane ownership per driver; lane k covers data bits [k*LANE_W +: LANE_W]. Full drivers tie all ones.
- ebus_data  out  WIDTH  registered merged EBUS data.
- ebus_parity  out  1  registered odd parity over ebus_data.
- ebus_parity_active  out  1  registered; 1 when any lane was driven.
- lane_owner  out  LANES*$clog2(N_DRV)  registered index of the winning driver per lane.
- conflict  out  1  sticky; two or more drivers claimed one lane in the same cycle.
- conflict_lane  out  $clog2(LANES)  lane of the first conflict.
- conflict_drv  out  2*$clog2(N_DRV)  the two lowest conflicting driver indices at the first conflict.
- conflict_cnt  out  8  saturating count of conflict cycles.
- stuck  out  1  sticky; a driver asserted drv_driving for STUCK_MAX consecutive cycles.
- stuck_drv  out  $clog2(N_DRV)  index of the first stuck driver.
- diag_clr  in  1  synchronous clear of all diagnostic state.

## Operation
- Per lane k, the candidate set is drivers with drv_driving[i] and drv_lanes[i][k] both asserted.
- The lowest-index candidate wins and its lane-k data slice is taken.
- A lane with no candidate outputs 0 and lane_owner 0.
- ebus_parity is the XOR-NOT of the merged data, so data plus parity has an odd number of ones.
- When no lane is driven: data 0, parity 1, parity_active 0.
- A conflict cycle is any cycle where any lane has two or more candidates.
- On the first conflict cycle after reset or clear:
  - set conflict;
  - capture the lowest conflicting lane in conflict_lane;
  - capture that lane's two lowest candidates in conflict_drv.
- Later conflicts do not change the captures. conflict_cnt increments on every conflict cycle and saturates at 255.
- Stuck detection uses one 16-bit run counter per driver.
  - The counter increments while drv_driving is asserted and resets to 0 when it is deasserted.
  - On reaching STUCK_MAX, set stuck and capture stuck_drv (lowest index if several drivers reach it in the same cycle). The counter holds at STUCK_MAX.
- diag_clr clears conflict, captures, conflict_cnt, stuck, stuck_drv and all run counters.
- If diag_clr coincides with a new event, the clear wins; the event is not recorded that cycle.
- Reset mid-transfer forces all outputs to their reset values; the first merged output appears 1 cycle after reset_l deasserts.

## Timing
- Data path latency is 1 cycle: inputs sampled at edge n appear on ebus_data, parity and lane_owner after edge n.
- Diagnostics update on the same edge as the data they describe.
- Reset values: ebus_data 0, ebus_parity 1, ebus_parity_active 0, lane_owner 0, conflict 0, conflict_lane 0, conflict_drv 0, conflict_cnt 0, stuck 0, stuck_drv 0, run counters 0.
- There is no handshake; drivers must hold data while driving. The arbiter never backpressures.

## Configuration
- EBUS_CONFLICT_LOG_EN defined: conflict, conflict_lane, conflict_drv and conflict_cnt are implemented as specified.
- Undefined: those four outputs are tied to 0 and their logic is removed.
- Merging, parity and stuck detection are identical either way.

## Structure
- Package ebus_arb_pkg holds the default LANE_W and WIDTH and a typedef for a lane slice.
- The package also holds the function computing the odd-parity bit.
- One sub-module, ebus_lane_pick, takes the candidate vector for a lane and returns the winner index, an any flag and a multiple flag.
- ebus_lane_pick also returns the two lowest candidate indices for conflict capture. It is instantiated LANES times in a generate loop.

## Test plan
- Driver 3 only, all lanes, data 0o123456701234: next cycle ebus_data 0o123456701234, every lane_owner 3, parity_active 1, parity matches odd parity, conflict 0.
- Slice merge, with drivers 10..15 each owning one lane k = i-10, in the same cycle: lane k equals driver 10+k's slice, lane_owner[k] = 10+k, conflict 0.
- Drivers 2 and 5 both own lane 1 for 3 cycles: output carries driver 2's data, conflict 1, conflict_lane 1, conflict_drv {2,5}, conflict_cnt 3. diag_clr then zeroes all of them.
- 300 conflict cycles: conflict_cnt saturates at 255.
- Driver 7 driving continuously with STUCK_MAX 16: stuck rises after 16 cycles with stuck_drv 7. Dropping drv_driving at 15 cycles, then reasserting, keeps stuck 0 until 16 new cycles elapse.
- reset_l pulsed low mid-transfer: all outputs return to reset values asynchronously, and merged data reappears 1 cycle after release.
